multicycle_ctrl: RTL and testbench

Moore-style sequencing controller for the multi-cycle variant of the processor. Fetch, decode, execute, memory and writeback share one ALU and one unified instruction/data memory, so each instruction takes several cycles. The block decodes the same instruction fields as the single-cycle control (Op, Funct, Rd) plus Cond, and evaluates conditional execution against an internal NZCV register. A mem_ready handshake stretches memory states, and a watchdog traps hung accesses.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/cond_check.sv | 34 +++
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state, datapath-select and instruction-field encodings for multicycle_ctrl
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_ALUWB    = 4'd4,
        ST_MEMADR   = 4'd5,
        ST_MEMREAD  = 4'd6,
        ST_MEMWRITE = 4'd7,
        ST_MEMWB    = 4'd8,
        ST_FAULT    = 4'd9,
        ST_BRANCH   = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - evaluates the instruction condition field against saved NZCV flags
module cond_check (
    input  logic [3:0] instr_cond,
    input  logic [3:0] flags,
    output logic       cond_pass
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_pass = 1'b0;
        case (instr_cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle processor sequencer with conditional execution and memory watchdog
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [3:0] instr_cond,
    input  logic [1:0] instr_op,
    input  logic [5:0] instr_funct,
    input  logic [3:0] instr_rd,
    input  logic [3:0] alu_flags,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_cntrl,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic       fault,
    output logic [3:0] state_dbg
);

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        flags;
    logic              cond_pass;
    logic              cnt_inc;
    logic              flags_we;
    logic [3:0]        cmd;
    logic              rd_is_pc;

    assign cmd       = instr_funct[4:1];
    assign rd_is_pc  = (instr_rd == 4'd15);
    assign state_dbg = state;

    cond_check u_cond_check (
        .instr_cond (instr_cond),
        .flags      (flags),
        .cond_pass  (cond_pass)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
            flags    <= 4'b0000;
        end else begin
            state <= next_state;
            // any state change clears the counter; only the three memory states use it
            if (next_state != state)
                wait_cnt <= '0;
            else if (cnt_inc)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (flags_we)
                flags <= alu_flags;
        end
    end

    always_comb begin
        next_state = state;
        cnt_inc    = 1'b0;
        flags_we   = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_cntrl  = ALU_ADD;
        result_src = RES_ALUOUT;
        imm_src    = IMM_DP;
        reg_src    = 2'b00;
        fault      = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_read   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = ST_DECODE;
                end else if (wait_cnt == WAIT_LIM) begin
                    next_state = ST_FAULT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (!cond_pass)
                    next_state = ST_FETCH;
                else begin
                    case (instr_op)
                        OP_DP:   next_state = instr_funct[5] ? ST_EXEC_I : ST_EXEC_R;
                        OP_MEM:  next_state = ST_MEMADR;
                        OP_BR:   next_state = ST_BRANCH;
                        default: next_state = ST_FAULT;
                    endcase
                end
            end
            ST_EXEC_R, ST_EXEC_I: begin
                alu_src_b  = (state == ST_EXEC_I) ? SRCB_IMM : SRCB_REG;
                imm_src    = IMM_DP;
                next_state = (cmd == CMD_CMP) ? ST_FETCH : ST_ALUWB;
                flags_we   = instr_funct[0] || (cmd == CMD_CMP);
                case (cmd)
                    CMD_ADD: alu_cntrl = ALU_ADD;
                    CMD_SUB: alu_cntrl = ALU_SUB;
                    CMD_AND: alu_cntrl = ALU_AND;
                    CMD_ORR: alu_cntrl = ALU_ORR;
                    CMD_CMP: alu_cntrl = ALU_SUB;
                    default: begin
                        next_state = ST_FAULT;
                        flags_we   = 1'b0;
                    end
                endcase
            end
            ST_ALUWB: begin
                result_src = RES_ALUOUT;
                pc_write   = rd_is_pc;
                reg_write  = !rd_is_pc;
                next_state = ST_FETCH;
            end
            ST_MEMADR: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_MEM;
                next_state = instr_funct[0] ? ST_MEMREAD : ST_MEMWRITE;
            end
            ST_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready)
                    next_state = ST_MEMWB;
                else if (wait_cnt == WAIT_LIM)
                    next_state = ST_FAULT;
                else
                    cnt_inc = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src   = 1'b1;
                reg_src   = 2'b10;
                mem_write = 1'b1;
                if (mem_ready)
                    next_state = ST_FETCH;
                else if (wait_cnt == WAIT_LIM)
                    next_state = ST_FAULT;
                else
                    cnt_inc = 1'b1;
            end
            ST_MEMWB: begin
                result_src = RES_DATA;
                pc_write   = rd_is_pc;
                reg_write  = !rd_is_pc;
                next_state = ST_FETCH;
            end
            ST_BRANCH: begin
                imm_src    = IMM_BR;
                alu_src_b  = SRCB_IMM;
                alu_cntrl  = ALU_ADD;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                next_state = ST_FETCH;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: next_state = ST_FAULT;
        endcase

        // reset state is FETCH, but nothing may strobe while reset is held
        if (!reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            adr_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_cntrl  = 2'b00;
            result_src = 2'b00;
            imm_src    = 2'b00;
            reg_src    = 2'b00;
            fault      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       sysclk;
    logic       reset;
    logic [3:0] instr_cond;
    logic [1:0] instr_op;
    logic [5:0] instr_funct;
    logic [3:0] instr_rd;
    logic [3:0] alu_flags;
    logic       mem_ready;
    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_cntrl, result_src, imm_src, reg_src;
    logic       fault;
    logic [3:0] state_dbg;

    int tests = 0;
    int fails = 0;

    multicycle_ctrl #(.WAIT_MAX(15), .WAIT_W(4)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .instr_cond  (instr_cond),
        .instr_op    (instr_op),
        .instr_funct (instr_funct),
        .instr_rd    (instr_rd),
        .alu_flags   (alu_flags),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .adr_src     (adr_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_cntrl   (alu_cntrl),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .reg_src     (reg_src),
        .fault       (fault),
        .state_dbg   (state_dbg)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r);
        instr_cond  = c;
        instr_op    = o;
        instr_funct = f;
        instr_rd    = r;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        tick();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        alu_flags = 4'b0000;
        mem_ready = 1'b1;
        set_instr(4'hE, 2'b00, 6'b000000, 4'd0);
        tick();
        tick();
        check("rst_state", 8'(state_dbg), 8'd0);
        check("rst_mem_read", 8'(mem_read), 8'd0);
        check("rst_srcb", 8'(alu_src_b), 8'd0);
        check("rst_fault", 8'(fault), 8'd0);

        // ADD R1,R2,R3
        reset = 1'b1;
        set_instr(4'hE, 2'b00, 6'b001000, 4'd1);
        #1;
        check("add_c1_state", 8'(state_dbg), 8'd0);
        check("add_c1_irw", 8'(ir_write), 8'd1);
        check("add_c1_pcw", 8'(pc_write), 8'd1);
        check("add_c1_srcb", 8'(alu_src_b), 8'd2);
        tick();
        check("add_c2_state", 8'(state_dbg), 8'd1);
        check("add_c2_regw", 8'(reg_write), 8'd0);
        tick();
        check("add_c3_state", 8'(state_dbg), 8'd2);
        check("add_c3_alu", 8'(alu_cntrl), 8'd0);
        check("add_c3_regw", 8'(reg_write), 8'd0);
        tick();
        check("add_c4_state", 8'(state_dbg), 8'd4);
        check("add_c4_regw", 8'(reg_write), 8'd1);
        check("add_c4_pcw", 8'(pc_write), 8'd0);
        tick();
        check("add_end", 8'(state_dbg), 8'd0);

        // SUBS R0,R0,#1 setting Z, then BEQ taken
        set_instr(4'hE, 2'b00, 6'b100101, 4'd0);
        alu_flags = 4'b0100;
        tick();
        tick();
        check("subs_state", 8'(state_dbg), 8'd3);
        check("subs_alu", 8'(alu_cntrl), 8'd1);
        check("subs_srcb", 8'(alu_src_b), 8'd1);
        tick();
        alu_flags = 4'b0000;
        tick();
        set_instr(4'h0, 2'b10, 6'b000000, 4'd0);
        tick();
        tick();
        check("beq_t_state", 8'(state_dbg), 8'd10);
        check("beq_t_pcw", 8'(pc_write), 8'd1);
        check("beq_t_imm", 8'(imm_src), 8'd2);
        tick();
        check("beq_t_end", 8'(state_dbg), 8'd0);

        // SUBS clearing Z, then BEQ not taken even with Z live on the ALU
        set_instr(4'hE, 2'b00, 6'b100101, 4'd0);
        alu_flags = 4'b0000;
        tick();
        tick();
        tick();
        alu_flags = 4'b0100;
        tick();
        set_instr(4'h0, 2'b10, 6'b000000, 4'd0);
        tick();
        check("beq_nt_dec", 8'(state_dbg), 8'd1);
        tick();
        check("beq_nt_end", 8'(state_dbg), 8'd0);

        // CMP sets Z in 3 cycles; BNE then falls through
        set_instr(4'hE, 2'b00, 6'b010101, 4'd0);
        alu_flags = 4'b0100;
        tick();
        tick();
        check("cmp_state", 8'(state_dbg), 8'd2);
        check("cmp_alu", 8'(alu_cntrl), 8'd1);
        tick();
        check("cmp_end", 8'(state_dbg), 8'd0);
        alu_flags = 4'b0000;
        set_instr(4'h1, 2'b10, 6'b000000, 4'd0);
        tick();
        tick();
        check("bne_nt_end", 8'(state_dbg), 8'd0);

        // LDR R4,[R5,#8] with three wait cycles
        set_instr(4'hE, 2'b01, 6'b011001, 4'd4);
        tick();
        tick();
        check("ldr_adr_state", 8'(state_dbg), 8'd5);
        check("ldr_adr_srcb", 8'(alu_src_b), 8'd1);
        check("ldr_adr_imm", 8'(imm_src), 8'd1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ldr_wait_state", 8'(state_dbg), 8'd6);
            check("ldr_wait_rd", 8'(mem_read), 8'd1);
            check("ldr_wait_regw", 8'(reg_write), 8'd0);
        end
        mem_ready = 1'b1;
        #1;
        check("ldr_rd4", 8'(mem_read), 8'd1);
        check("ldr_adrsrc", 8'(adr_src), 8'd1);
        tick();
        check("ldr_wb_state", 8'(state_dbg), 8'd8);
        check("ldr_wb_regw", 8'(reg_write), 8'd1);
        check("ldr_wb_res", 8'(result_src), 8'd1);
        check("ldr_wb_pcw", 8'(pc_write), 8'd0);
        tick();
        check("ldr_end", 8'(state_dbg), 8'd0);

        // mem_ready on the WAIT_MAX cycle still completes the load
        set_instr(4'hE, 2'b01, 6'b011001, 4'd2);
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("wmax_state", 8'(state_dbg), 8'd6);
        mem_ready = 1'b1;
        #1;
        tick();
        check("wmax_wb", 8'(state_dbg), 8'd8);
        tick();

        // LDR PC
        set_instr(4'hE, 2'b01, 6'b011001, 4'd15);
        tick();
        tick();
        tick();
        tick();
        check("ldrpc_state", 8'(state_dbg), 8'd8);
        check("ldrpc_pcw", 8'(pc_write), 8'd1);
        check("ldrpc_regw", 8'(reg_write), 8'd0);
        tick();

        // STR with memory never ready traps after 16 cycles in MEMWRITE
        set_instr(4'hE, 2'b01, 6'b011000, 4'd3);
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check("str_state", 8'(state_dbg), 8'd7);
        check("str_memw", 8'(mem_write), 8'd1);
        check("str_regsrc", 8'(reg_src), 8'd2);
        for (int i = 0; i < 15; i++) tick();
        check("str_last_wait", 8'(state_dbg), 8'd7);
        tick();
        check("str_fault_state", 8'(state_dbg), 8'd9);
        check("str_fault", 8'(fault), 8'd1);
        check("str_fault_memw", 8'(mem_write), 8'd0);
        check("str_fault_pcw", 8'(pc_write), 8'd0);
        mem_ready = 1'b1;
        tick();
        check("str_fault_hold", 8'(state_dbg), 8'd9);
        reset = 1'b0;
        #1;
        check("str_rst_fault", 8'(fault), 8'd0);
        check("str_rst_state", 8'(state_dbg), 8'd0);
        tick();
        reset = 1'b1;
        #1;
        check("str_rel_state", 8'(state_dbg), 8'd0);
        check("str_rel_rd", 8'(mem_read), 8'd1);

        // undefined op traps from DECODE
        set_instr(4'hE, 2'b11, 6'b000000, 4'd0);
        tick();
        tick();
        check("undef_op", 8'(state_dbg), 8'd9);
        reset_pulse();

        // unsupported dp command traps from EXEC
        set_instr(4'hE, 2'b00, 6'b000010, 4'd1);
        tick();
        tick();
        tick();
        check("bad_cmd", 8'(state_dbg), 8'd9);
        reset_pulse();

        // set Z, then reset during ALUWB clears outputs and flags
        set_instr(4'hE, 2'b00, 6'b100101, 4'd0);
        alu_flags = 4'b0100;
        tick();
        tick();
        tick();
        tick();
        alu_flags = 4'b0000;
        set_instr(4'hE, 2'b00, 6'b001000, 4'd1);
        tick();
        tick();
        tick();
        check("mid_wb_regw", 8'(reg_write), 8'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_regw", 8'(reg_write), 8'd0);
        check("mid_rst_state", 8'(state_dbg), 8'd0);
        tick();
        reset = 1'b1;
        set_instr(4'h0, 2'b10, 6'b000000, 4'd0);
        alu_flags = 4'b0100;
        #1;
        check("mid_rel_state", 8'(state_dbg), 8'd0);
        tick();
        tick();
        check("mid_beq_nt", 8'(state_dbg), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
